// File: rtl/alu_bitserial_seq_if.sv
// CPU-side request/response bundle for the bit-serial ALU sequencer.
interface alu_bitserial_seq_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [3:0]       ALU_control;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             cout;
  logic             overflow;

  // Requester side: issues operations, observes result and flags.
  modport master (
    output start, ALU_control, src1, src2,
    input  busy, done, result, zero, cout, overflow
  );

  // Sequencer side.
  modport slave (
    input  start, ALU_control, src1, src2,
    output busy, done, result, zero, cout, overflow
  );
endinterface

// File: rtl/alu_bitserial_seq.sv
// Bit-serial ALU sequencer: walks WIDTH-bit operands LSB first through one
// external 1-bit ALU slice, carrying between cycles. SLT uses a second pass
// that feeds the computed sign-compare bit into the slice's less input.
module alu_bitserial_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  alu_bitserial_seq_if.slave  bus,
  output logic                slice_src1,
  output logic                slice_src2,
  output logic                slice_less,
  output logic                slice_A_invert,
  output logic                slice_B_invert,
  output logic                slice_cin,
  output logic [1:0]          slice_operation,
  input  logic                slice_result,
  input  logic                slice_cout
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StSlt2 = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [CNT_W-1:0] IdxLast = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       ctl_q, ctl_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             set_q, set_d;

  logic       a_inv, b_inv, is_arith, is_slt, active, idx_last, cin_bit;
  logic [1:0] op;

  // Decode the latched control code into slice controls for the current pass.
  always_comb begin
    a_inv    = 1'b0;
    b_inv    = 1'b0;
    op       = 2'b00;
    is_arith = 1'b0;
    is_slt   = 1'b0;
    case (ctl_q)
      4'b0001: op = 2'b01;
      4'b0010: begin
        op       = 2'b10;
        is_arith = 1'b1;
      end
      4'b0110: begin
        b_inv    = 1'b1;
        op       = 2'b10;
        is_arith = 1'b1;
      end
      4'b1100: begin
        a_inv = 1'b1;
        b_inv = 1'b1;
      end
      4'b0111: begin
        b_inv  = 1'b1;
        op     = 2'b10;
        is_slt = 1'b1;
      end
      default: ; // unsupported codes run as AND
    endcase
    // Second SLT pass: LESS op, so each result bit is just the less input.
    if (state_q == StSlt2) begin
      a_inv = 1'b0;
      b_inv = 1'b1;
      op    = 2'b11;
    end
  end

  assign active   = (state_q == StRun) || (state_q == StSlt2);
  assign idx_last = (idx_q == IdxLast);
  // B_inv doubles as the +1 of two's-complement negation on bit 0.
  assign cin_bit  = (idx_q == '0) ? b_inv : carry_q;

  // Slice drive; everything forced to 0 outside the two working states.
  always_comb begin
    slice_src1      = active & a_q[idx_q];
    slice_src2      = active & b_q[idx_q];
    slice_less      = (state_q == StSlt2) && (idx_q == '0) && set_q;
    slice_A_invert  = active & a_inv;
    slice_B_invert  = active & b_inv;
    slice_cin       = active & cin_bit;
    slice_operation = active ? op : 2'b00;
  end

  // Next-state: accept, per-bit capture, end-of-pass flag capture.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    ctl_d    = ctl_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    zero_d   = zero_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    set_d    = set_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d      = bus.src1;
          b_d      = bus.src2;
          ctl_d    = bus.ALU_control;
          idx_d    = '0;
          carry_d  = 1'b0;
          result_d = '0;
          zero_d   = 1'b0;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          set_d    = 1'b0;
          state_d  = StRun;
        end
      end
      StRun: begin
        result_d[idx_q] = slice_result;
        carry_d         = slice_cout;
        idx_d           = idx_q + CNT_W'(1);
        if (idx_last) begin
          idx_d = '0;
          if (is_arith) begin
            ovf_d  = cin_bit ^ slice_cout;
            cout_d = slice_cout;
          end
          if (is_slt) begin
            // Sign of A-B corrected for overflow gives signed A < B.
            set_d   = slice_result ^ (cin_bit ^ slice_cout);
            state_d = StSlt2;
          end else begin
            zero_d  = (result_d == '0);
            state_d = StDone;
          end
        end
      end
      StSlt2: begin
        result_d[idx_q] = slice_result;
        carry_d         = slice_cout;
        idx_d           = idx_q + CNT_W'(1);
        if (idx_last) begin
          idx_d   = '0;
          zero_d  = (result_d == '0);
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      ctl_q    <= 4'b0000;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      set_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ctl_q    <= ctl_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      set_q    <= set_d;
    end
  end

  assign bus.busy     = (state_q != StIdle);
  assign bus.done     = (state_q == StDone);
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Directed bench for alu_bitserial_seq with a behavioural 1-bit ALU slice.
module tb_alu_bitserial_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu_bitserial_seq_if #(.WIDTH(32)) bus ();

  logic       slice_src1, slice_src2, slice_less, slice_A_invert, slice_B_invert, slice_cin;
  logic [1:0] slice_operation;
  logic       slice_result, slice_cout;

  int total = 0;
  int bad   = 0;

  alu_bitserial_seq #(.WIDTH(32), .CNT_W(5)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .slice_src1      (slice_src1),
    .slice_src2      (slice_src2),
    .slice_less      (slice_less),
    .slice_A_invert  (slice_A_invert),
    .slice_B_invert  (slice_B_invert),
    .slice_cin       (slice_cin),
    .slice_operation (slice_operation),
    .slice_result    (slice_result),
    .slice_cout      (slice_cout)
  );

  always #5 clk = ~clk;

  // Reference 1-bit slice: AND / OR / full-add / pass-less.
  logic sa, sb;
  always_comb begin
    sa         = slice_src1 ^ slice_A_invert;
    sb         = slice_src2 ^ slice_B_invert;
    slice_cout = (sa & sb) | (sa & slice_cin) | (sb & slice_cin);
    case (slice_operation)
      2'b00:   slice_result = sa & sb;
      2'b01:   slice_result = sa | sb;
      2'b10:   slice_result = sa ^ sb ^ slice_cin;
      default: slice_result = slice_less;
    endcase
  end

  logic [7:0] slice_vec;
  assign slice_vec = {slice_src1, slice_src2, slice_less, slice_A_invert, slice_B_invert,
                      slice_cin, slice_operation};

  int   busy_cnt, done_at, done_cnt;
  logic first_cin, binv_all;

  // Issue one operation; cycle 1 is the first cycle after the accepting edge.
  task automatic run_op(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start       = 1'b1;
    bus.ALU_control = ctl;
    bus.src1        = a;
    bus.src2        = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.src1  = ~a;  // must not leak into a latched operation
    bus.src2  = ~b;
    busy_cnt  = 0;
    done_cnt  = 0;
    done_at   = 0;
    first_cin = 1'b0;
    binv_all  = 1'b1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (cyc == 1) first_cin = slice_cin;
      if (!bus.busy) break;
      busy_cnt++;
      if (bus.done) begin
        done_cnt++;
        done_at = cyc;
      end else if (!slice_B_invert) begin
        binv_all = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b1;  // rst must win over a simultaneous start
    bus.ALU_control = 4'b0010;
    bus.src1  = 32'h1234_5678;
    bus.src2  = 32'h1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result); end
    total++; if ({bus.zero, bus.cout, bus.overflow} !== 3'b000) begin bad++;
      $display("FAIL reset_flags got=%b want=000", {bus.zero, bus.cout, bus.overflow}); end
    total++; if (slice_vec !== 8'h00) begin bad++; $display("FAIL reset_slice got=%h want=00", slice_vec); end
    bus.start = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_no_accept got=%b want=0", bus.busy); end
  endtask

  task automatic test_add();
    run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001);
    total++; if (bus.result !== 32'h8000_0000) begin bad++; $display("FAIL add_result got=%h want=80000000", bus.result); end
    total++; if (bus.overflow !== 1'b1) begin bad++; $display("FAIL add_ovf got=%b want=1", bus.overflow); end
    total++; if (bus.cout !== 1'b0) begin bad++; $display("FAIL add_cout got=%b want=0", bus.cout); end
    total++; if (bus.zero !== 1'b0) begin bad++; $display("FAIL add_zero got=%b want=0", bus.zero); end
    total++; if (done_at !== 33) begin bad++; $display("FAIL add_done_cycle got=%0d want=33", done_at); end
    total++; if (busy_cnt !== 33) begin bad++; $display("FAIL add_busy_cycles got=%0d want=33", busy_cnt); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL add_done_pulses got=%0d want=1", done_cnt); end
  endtask

  task automatic test_sub();
    run_op(4'b0110, 32'h0000_0005, 32'h0000_0005);
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL sub_result got=%h want=0", bus.result); end
    total++; if (bus.zero !== 1'b1) begin bad++; $display("FAIL sub_zero got=%b want=1", bus.zero); end
    total++; if (bus.cout !== 1'b1) begin bad++; $display("FAIL sub_cout got=%b want=1", bus.cout); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL sub_ovf got=%b want=0", bus.overflow); end
    total++; if (first_cin !== 1'b1) begin bad++; $display("FAIL sub_cin0 got=%b want=1", first_cin); end
    total++; if (binv_all !== 1'b1) begin bad++; $display("FAIL sub_binv got=%b want=1", binv_all); end
    run_op(4'b0110, 32'h0000_0003, 32'h0000_0005);
    total++; if (bus.result !== 32'hFFFF_FFFE) begin bad++; $display("FAIL sub_neg_result got=%h want=fffffffe", bus.result); end
    total++; if ({bus.cout, bus.overflow, bus.zero} !== 3'b000) begin bad++;
      $display("FAIL sub_neg_flags got=%b want=000", {bus.cout, bus.overflow, bus.zero}); end
  endtask

  task automatic test_slt();
    run_op(4'b0111, 32'hFFFF_FFFF, 32'h0000_0001);
    total++; if (bus.result !== 32'h1) begin bad++; $display("FAIL slt_result got=%h want=1", bus.result); end
    total++; if (done_at !== 65) begin bad++; $display("FAIL slt_done_cycle got=%0d want=65", done_at); end
    total++; if (busy_cnt !== 65) begin bad++; $display("FAIL slt_busy_cycles got=%0d want=65", busy_cnt); end
    total++; if ({bus.cout, bus.overflow, bus.zero} !== 3'b000) begin bad++;
      $display("FAIL slt_flags got=%b want=000", {bus.cout, bus.overflow, bus.zero}); end
    run_op(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000);
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL slt_ovf_result got=%h want=0", bus.result); end
    total++; if ({bus.cout, bus.overflow, bus.zero} !== 3'b001) begin bad++;
      $display("FAIL slt_ovf_flags got=%b want=001", {bus.cout, bus.overflow, bus.zero}); end
  endtask

  task automatic test_logic();
    run_op(4'b1100, 32'h0, 32'h0);
    total++; if (bus.result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL nor_result got=%h want=ffffffff", bus.result); end
    total++; if ({bus.cout, bus.overflow, bus.zero} !== 3'b000) begin bad++;
      $display("FAIL nor_flags got=%b want=000", {bus.cout, bus.overflow, bus.zero}); end
    run_op(4'b0001, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    total++; if (bus.result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL or_result got=%h want=ffffffff", bus.result); end
    total++; if ({bus.cout, bus.overflow, bus.zero} !== 3'b000) begin bad++;
      $display("FAIL or_flags got=%b want=000", {bus.cout, bus.overflow, bus.zero}); end
    run_op(4'b0000, 32'hF0F0_F0F0, 32'h0F0F_0F0F);
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL and_result got=%h want=0", bus.result); end
    total++; if ({bus.cout, bus.overflow, bus.zero} !== 3'b001) begin bad++;
      $display("FAIL and_flags got=%b want=001", {bus.cout, bus.overflow, bus.zero}); end
  endtask

  task automatic test_unsupported();
    run_op(4'b1111, 32'hFFFF_0000, 32'h0FF0_0FF0);
    total++; if (bus.result !== 32'h0FF0_0000) begin bad++; $display("FAIL unsup_result got=%h want=0ff00000", bus.result); end
    total++; if ({bus.cout, bus.overflow, bus.zero} !== 3'b000) begin bad++;
      $display("FAIL unsup_flags got=%b want=000", {bus.cout, bus.overflow, bus.zero}); end
    bus.src1 = 32'hFFFF_FFFF;
    bus.src2 = 32'hFFFF_FFFF;
    @(negedge clk);
    total++; if (slice_vec !== 8'h00) begin bad++; $display("FAIL idle_slice got=%h want=00", slice_vec); end
    total++; if (bus.result !== 32'h0FF0_0000) begin bad++; $display("FAIL result_hold got=%h want=0ff00000", bus.result); end
  endtask

  task automatic test_reset_mid();
    logic saw_done;
    logic busy10;
    saw_done = 1'b0;
    busy10   = 1'b0;
    @(negedge clk);
    bus.start       = 1'b1;  // held high through the run
    bus.ALU_control = 4'b0010;
    bus.src1        = 32'h0000_0003;
    bus.src2        = 32'h0000_0001;
    @(posedge clk);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
      if (cyc == 10) busy10 = bus.busy;
    end
    total++; if (busy10 !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b want=1", busy10); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", bus.busy); end
    total++; if (bus.result !== 32'h0) begin bad++; $display("FAIL mid_rst_result got=%h want=0", bus.result); end
    total++; if (slice_vec !== 8'h00) begin bad++; $display("FAIL mid_rst_slice got=%h want=00", slice_vec); end
    rst       = 1'b0;
    bus.start = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL mid_rst_done got=%b want=0", saw_done); end
  endtask

  task automatic test_back_to_back();
    int          first_done;
    int          second_done;
    logic [31:0] first_res;
    logic        busy34;
    logic        busy35;
    first_done  = 0;
    second_done = 0;
    first_res   = 32'h0;
    busy34      = 1'b1;
    busy35      = 1'b0;
    @(negedge clk);
    bus.start       = 1'b1;
    bus.ALU_control = 4'b0010;
    bus.src1        = 32'd1;
    bus.src2        = 32'd2;
    @(posedge clk);
    for (int cyc = 1; cyc <= 120; cyc++) begin
      @(negedge clk);
      if (bus.done && first_done == 0) begin
        first_done = cyc;
        first_res  = bus.result;
        bus.src1   = 32'd10;  // taken only at the IDLE-cycle accept
        bus.src2   = 32'd20;
      end else if (bus.done && second_done == 0) begin
        second_done = cyc;
      end
      if (cyc == 34) busy34 = bus.busy;
      if (cyc == 35) begin
        busy35    = bus.busy;
        bus.start = 1'b0;
      end
      if (second_done != 0) break;
    end
    bus.start = 1'b0;
    total++; if (first_done !== 33) begin bad++; $display("FAIL b2b_first_done got=%0d want=33", first_done); end
    total++; if (first_res !== 32'd3) begin bad++; $display("FAIL b2b_first_result got=%h want=3", first_res); end
    total++; if (busy34 !== 1'b0) begin bad++; $display("FAIL b2b_idle_gap got=%b want=0", busy34); end
    total++; if (busy35 !== 1'b1) begin bad++; $display("FAIL b2b_reaccept got=%b want=1", busy35); end
    total++; if (second_done !== 67) begin bad++; $display("FAIL b2b_second_done got=%0d want=67", second_done); end
    total++; if (bus.result !== 32'd30) begin bad++; $display("FAIL b2b_second_result got=%h want=1e", bus.result); end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bus.start       = 1'b0;
    bus.ALU_control = 4'b0000;
    bus.src1        = 32'h0;
    bus.src2        = 32'h0;
    test_reset();
    test_add();
    test_sub();
    test_slt();
    test_logic();
    test_unsupported();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_bitserial_seq.md
Name: alu_bitserial_seq

Overview:
Bit-serial sequencer that runs full-width ALU operations through a single external 1-bit ALU slice (AND/OR/ADD/LESS slice with A/B invert and carry in/out). It latches two operands and an ALU control code on a start handshake. It then drives the slice one bit per cycle, LSB first, holding the carry between cycles, and assembles the result. It also produces zero, carry-out and overflow flags. It sits between the CPU datapath's ALU-control decode and the shared slice, trading latency for area.

Parameters:
WIDTH, 32, operand/result width in bits (≥2)
CNT_W, 5, bit-index counter width, clog2(WIDTH)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; accepted only in IDLE
ALU_control  input  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR, 0111 SLT
src1  input  WIDTH  operand A, sampled on accept
src2  input  WIDTH  operand B, sampled on accept
busy  output  1  high whenever state ≠ IDLE
done  output  1  one-cycle pulse, result/flags valid
result  output  WIDTH  assembled result, held until next accept
zero  output  1  result == 0
cout  output  1  final carry for ADD/SUB, else 0
overflow  output  1  signed overflow for ADD/SUB, else 0
slice_src1  output  1  current bit of A
slice_src2  output  1  current bit of B
slice_less  output  1  less input to slice
slice_A_invert  output  1  A invert to slice
slice_B_invert  output  1  B invert to slice
slice_cin  output  1  carry in to slice
slice_operation  output  2  00 AND, 01 OR, 10 ADD, 11 LESS
slice_result  input  1  slice result bit (combinational from slice outputs)
slice_cout  input  1  slice carry out

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset state: IDLE. Outputs: busy=0, done=0, result=0, zero=0, cout=0, overflow=0. All slice_* outputs are 0; the bit index and carry register are 0.
- States: IDLE, RUN, SLT2, DONE.
- IDLE: on start=1, latch src1, src2 and ALU_control; clear idx and result; go to RUN.
  - start is ignored in every other state, including DONE.
- Decode, per code:
  - AND: A_inv 0, B_inv 0, op 00.
  - OR: A_inv 0, B_inv 0, op 01.
  - ADD: A_inv 0, B_inv 0, op 10.
  - SUB: A_inv 0, B_inv 1, op 10.
  - NOR: A_inv 1, B_inv 1, op 00.
  - SLT, first pass: A_inv 0, B_inv 1, op 10.
  - Unsupported codes execute as AND.
- RUN, cycle with index idx:
  - slice_src1/slice_src2 = operand bits [idx]. slice_less = 0.
  - slice_cin = B_inv when idx=0, else the carry register.
  - At the edge: result[idx] ← slice_result, carry ← slice_cout, idx++.
- At the edge with idx = WIDTH-1:
  - overflow ← slice_cin ^ slice_cout (ADD/SUB only).
  - cout ← slice_cout (ADD/SUB only).
  - For SLT, capture set = slice_result ^ (slice_cin ^ slice_cout), clear idx, go to SLT2.
  - Otherwise go to DONE.
- SLT2: op 11, B_inv 1; slice_less = set when idx=0, else 0. Write result bit per cycle as in RUN. At idx = WIDTH-1 go to DONE.
  - SLT reports cout=0 and overflow=0.
- DONE: done=1 for exactly one cycle, then IDLE. zero = (result == 0) is valid while done=1 and stays valid afterwards.
- Latency: start sampled at edge 0 → done high in the cycle after edge WIDTH, i.e. WIDTH+1 cycles. SLT takes 2·WIDTH+1 cycles.
- result, zero, cout and overflow hold their values until the next accepted start clears them.
- slice_* outputs are 0 in IDLE and DONE.
- Carry logic: the carry register is ignored for logic ops; the slice's cout is still sampled but does not affect flags.
- Reset mid-operation: rst wins over every other event. The operation is abandoned, done never pulses, and all outputs return to reset values the cycle after rst.
- Simultaneous rst and start: rst wins.
- Back-to-back: a start asserted in the DONE cycle is ignored. It is accepted if still high in the following IDLE cycle.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 → result 0x80000000, overflow 1, cout 0, zero 0; done exactly 33 cycles after start is sampled, busy high for 33 cycles.
- SUB 0x00000005 − 0x00000005 → result 0, zero 1, cout 1, overflow 0. Check slice_cin=1 at idx 0 and slice_B_invert=1 throughout.
- SLT with src1 0xFFFFFFFF, src2 0x00000001 → result 0x00000001, done at cycle 65. Then SLT with src1 0x7FFFFFFF, src2 0x80000000 (overflow case) → result 0.
- Logic ops on operands 0 and 0: NOR → 0xFFFFFFFF. OR 0xF0F0F0F0 | 0x0F0F0F0F → 0xFFFFFFFF. AND of the same pair → 0, zero 1. cout and overflow are 0 for all three.
- Assert rst at cycle 10 of an ADD → next cycle busy 0, result 0, no done pulse. Start held high throughout RUN is ignored, and a start in the DONE cycle is not accepted until IDLE.
- Unsupported code 1111 with 0xFFFF0000, 0x0FF00FF0 → AND result 0x0FF00000. Slice outputs are 0 in IDLE.
